pwm_multi_ch: RTL and testbench

- Parametrised multi-channel PWM generator, successor to the single-channel PWM_ADC stage in the ultrasound drive/sense path.
- One shared period counter drives CHANNELS independent duty comparators.
- Supports edge-aligned and center-aligned modes, with glitch-free double-buffered duty, period and mode updates at period boundaries.
- Downstream transducer drive and sampling logic synchronise to period_tick.

---
 rtl/pwm_multi_ch.sv | 114 +++++++++++
 tb/tb_pwm_multi_ch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared edge/center-aligned counter, per-channel duty compare, shadowed updates at period boundaries.
// Compare-to-output latency is 1 cycle; no backpressure, writes are accepted every cycle.
module pwm_multi_ch #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                mode,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick,
    output logic [CHANNELS-1:0] pending
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    logic [WIDTH-1:0]    cnt, cnt_nxt;
    dir_t                dir, dir_nxt;
    logic [WIDTH-1:0]    period_act;
    logic                mode_act;
    logic [WIDTH-1:0]    duty_shadow [CHANNELS];
    logic [WIDTH-1:0]    duty_act    [CHANNELS];
    logic [CHANNELS-1:0] write_hit;
    logic                boundary;
    logic                load;

    // Out-of-range channel indices match no channel, so they are dropped here.
    always_comb begin
        write_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            write_hit[i] = wr_en && (wr_ch == CH_W'(i));
        end
    end

    // With P=1 in center mode the top of the ramp is also the last cycle,
    // so cnt==1 counts as a boundary even before dir has turned.
    always_comb begin
        boundary = 1'b0;
        if (period_act == '0) begin
            boundary = 1'b1;
        end else if (!mode_act) begin
            boundary = (cnt == period_act);
        end else begin
            boundary = (cnt == WIDTH'(1)) &&
                       ((dir == DIR_DOWN) || (period_act == WIDTH'(1)));
        end
    end

    assign load = !enable || boundary;

    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (load) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (!mode_act) begin
            cnt_nxt = cnt + WIDTH'(1);
        end else if (dir == DIR_UP) begin
            if (cnt == period_act) begin
                cnt_nxt = cnt - WIDTH'(1);
                dir_nxt = DIR_DOWN;
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
            end
        end else begin
            cnt_nxt = cnt - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            dir         <= DIR_UP;
            period_act  <= '0;
            mode_act    <= 1'b0;
            pending     <= '0;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_shadow[i] <= '0;
                duty_act[i]    <= '0;
            end
        end else begin
            cnt         <= cnt_nxt;
            dir         <= dir_nxt;
            period_tick <= enable && boundary;
            if (load) begin
                period_act <= period;
                mode_act   <= mode;
                pending    <= write_hit;
            end else begin
                pending    <= pending | write_hit;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= enable && (cnt < duty_act[i]);
                // Old shadow is captured first, so a same-cycle write waits a period.
                if (load) begin
                    duty_act[i] <= duty_shadow[i];
                end
                if (write_hit[i]) begin
                    duty_shadow[i] <= wr_duty;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a phase-based period model.
module tb_pwm_multi_ch;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 4;

    logic                clk;
    logic                rst;
    logic                enable;
    logic                mode;
    logic [WIDTH-1:0]    period;
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [WIDTH-1:0]    wr_duty;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_tick;
    logic [CHANNELS-1:0] pending;

    pwm_multi_ch #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .period      (period),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: position k within the period; cnt is derived from k and the period shape.
    int               m_k, m_p, m_mode;
    int               m_shadow [CHANNELS];
    int               m_act    [CHANNELS];
    logic [CHANNELS-1:0] m_pend, m_pwm, m_hit;
    logic             m_tick, m_bnd;
    int               m_cnt, m_len;

    always @(posedge clk) begin
        if (rst) begin
            m_k = 0; m_p = 0; m_mode = 0;
            m_pend = '0; m_pwm = '0; m_tick = 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                m_shadow[i] = 0;
                m_act[i]    = 0;
            end
        end else begin
            if (m_p == 0)       m_len = 1;
            else if (m_mode != 0) m_len = 2 * m_p;
            else                m_len = m_p + 1;
            m_cnt = (m_mode != 0 && m_k > m_p) ? 2 * m_p - m_k : m_k;
            m_bnd = enable && (m_k == m_len - 1);
            for (int i = 0; i < CHANNELS; i++)
                m_pwm[i] = enable && (m_cnt < m_act[i]);
            m_tick = m_bnd;
            m_hit = '0;
            for (int i = 0; i < CHANNELS; i++)
                if (wr_en && int'(wr_ch) == i) m_hit[i] = 1'b1;
            if (!enable || m_bnd) begin
                for (int i = 0; i < CHANNELS; i++) m_act[i] = m_shadow[i];
                m_p    = int'(period);
                m_mode = int'(mode);
                m_k    = 0;
                m_pend = m_hit;
            end else begin
                m_k    = m_k + 1;
                m_pend = m_pend | m_hit;
            end
            for (int i = 0; i < CHANNELS; i++)
                if (m_hit[i]) m_shadow[i] = int'(wr_duty);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_pwm_out", 32'(pwm_out), 32'(m_pwm));
            chk("model_period_tick", 32'(period_tick), 32'(m_tick));
            chk("model_pending", 32'(pending), 32'(m_pend));
        end
    end

    int obs_hi [CHANNELS];
    int obs_tk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int n);
        for (int i = 0; i < CHANNELS; i++) obs_hi[i] = 0;
        obs_tk = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            for (int i = 0; i < CHANNELS; i++) obs_hi[i] += int'(pwm_out[i]);
            obs_tk += int'(period_tick);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 1200);
        chk("tick_seen", 32'(period_tick), 32'd1);
    endtask

    task automatic write(input int ch, input int d);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_duty = WIDTH'(d);
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 1'b0; period = '0;
        wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
        step();
        chk_on = 1'b1;
        step(); step();
        @(negedge clk);
        chk("reset_pwm_out", 32'(pwm_out), 32'd0);
        chk("reset_tick", 32'(period_tick), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);

        // 1: edge P=9, D=3 written while idle
        step();
        rst = 1'b0; period = 8'd9; mode = 1'b0;
        write(0, 3);
        step(); step();
        enable = 1'b1;
        repeat (2) @(negedge clk);
        observe(20);
        chk("t1_ch0_high", 32'(obs_hi[0]), 32'd6);
        chk("t1_ticks", 32'(obs_tk), 32'd2);

        // 2: duty extremes
        step();
        write(0, 0); write(1, 10); write(2, 255); write(3, 9);
        repeat (25) step();
        observe(20);
        chk("t2_ch0_high", 32'(obs_hi[0]), 32'd0);
        chk("t2_ch1_high", 32'(obs_hi[1]), 32'd20);
        chk("t2_ch2_high", 32'(obs_hi[2]), 32'd20);
        chk("t2_ch3_high", 32'(obs_hi[3]), 32'd18);

        // 3: mid-period write to ch1 at cnt=4
        wait_tick();
        repeat (4) step();
        write(1, 5);
        @(negedge clk);
        chk("t3_pending1", 32'(pending[1]), 32'd1);
        chk("t3_old_duty", 32'(pwm_out[1]), 32'd1);
        wait_tick();
        chk("t3_pending1_clr", 32'(pending[1]), 32'd0);
        observe(10);
        chk("t3_ch1_high", 32'(obs_hi[1]), 32'd5);

        // 5: write during boundary cycle plus an out-of-range write
        wait_tick();
        repeat (9) step();
        wr_en = 1'b1; wr_ch = 4'd2; wr_duty = 8'd7;
        step();
        wr_ch = 4'd7; wr_duty = 8'd0;
        @(negedge clk);
        chk("t5_tick", 32'(period_tick), 32'd1);
        chk("t5_pending2", 32'(pending[2]), 32'd1);
        step();
        wr_en = 1'b0;
        obs_hi[2] = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0) chk("t5_pending_mask", 32'(pending), 32'h4);
            obs_hi[2] += int'(pwm_out[2]);
            if (j == 9) begin
                chk("t5_tick2", 32'(period_tick), 32'd1);
                chk("t5_pending_clr", 32'(pending), 32'd0);
            end
        end
        chk("t5_ch2_old", 32'(obs_hi[2]), 32'd10);
        observe(10);
        chk("t5_ch2_new", 32'(obs_hi[2]), 32'd7);
        chk("t5_ch0_unchanged", 32'(obs_hi[0]), 32'd0);

        // 4: center mode P=4, D=2
        step();
        mode = 1'b1; period = 8'd4;
        write(0, 2);
        repeat (30) step();
        observe(16);
        chk("t4_ch0_high", 32'(obs_hi[0]), 32'd6);
        chk("t4_ticks", 32'(obs_tk), 32'd4 / 32'd2);

        // 6: reset with a pending write
        step();
        write(0, 8);
        rst = 1'b1; enable = 1'b0;
        step();
        rst = 1'b0; enable = 1'b1;
        @(negedge clk);
        chk("t6_pwm_out", 32'(pwm_out), 32'd0);
        chk("t6_tick", 32'(period_tick), 32'd0);
        chk("t6_pending", 32'(pending), 32'd0);
        observe(20);
        chk("t6_ch0_high", 32'(obs_hi[0]), 32'd0);

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 5000; c++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if ($urandom_range(0, 59) == 0) begin
                mode = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 6))
                    0: period = 8'd0;
                    1: period = 8'd1;
                    2: period = 8'd2;
                    3: period = 8'd3;
                    4: period = 8'd5;
                    5: period = 8'd9;
                    default: period = 8'd255;
                endcase
            end
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = 4'($urandom_range(0, 7));
            wr_duty = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 10));
        end
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
